// File: rtl/alu_arbiter.sv
// Round-robin front end that serialises two requesters onto a shared registered
// ALU, waits out its pipeline latency and returns each result as a one-cycle pulse.
module alu_arbiter #(
  parameter int unsigned DATA_W  = 3,
  parameter int unsigned OP_W    = 4,
  parameter int unsigned RES_W   = 6,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [RES_W-1:0]  rsp_result,
  output logic              rsp_err,
  output logic              busy,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_opcode,
  input  logic [RES_W-1:0]  alu_result
);

  localparam int unsigned CNT_W = 3;
  localparam logic [OP_W-1:0] OP_FIRST = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LAST  = OP_W'(12);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t            state;
  logic              prio;
  logic              owner;
  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic              grant1;
  logic              legal;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [OP_W-1:0]   sel_op;

  // Winner selection; ready is only offered in IDLE and never while in reset.
  always_comb begin
    accept = (state == IDLE) && !rst && (req0_valid || req1_valid);
    grant1 = req1_valid && (!req0_valid || prio);
    sel_a  = grant1 ? req1_a  : req0_a;
    sel_b  = grant1 ? req1_b  : req0_b;
    sel_op = grant1 ? req1_op : req0_op;
    legal  = (sel_op >= OP_FIRST) && (sel_op <= OP_LAST);
  end

  assign req0_ready = accept && !grant1;
  assign req1_ready = accept && grant1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      prio       <= 1'b0;
      owner      <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            prio  <= !grant1;
            owner <= grant1;
            busy  <= 1'b1;
            if (legal) begin
              alu_a      <= sel_a;
              alu_b      <= sel_b;
              alu_opcode <= sel_op;
              cnt        <= CNT_W'(ALU_LAT - 1);
              state      <= ISSUE;
            end else begin
              // Illegal opcode: answer straight away, leave the ALU untouched.
              rsp_result <= '0;
              rsp_err    <= 1'b1;
              rsp0_valid <= !grant1;
              rsp1_valid <= grant1;
              state      <= RESP;
            end
          end
        end
        ISSUE: begin
          if (cnt == '0) state <= CAPTURE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        CAPTURE: begin
          rsp_result <= alu_result;
          rsp_err    <= 1'b0;
          rsp0_valid <= !owner;
          rsp1_valid <= owner;
          state      <= RESP;
        end
        RESP: begin
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
